ahb_resp_gen: RTL and testbench

//  Parametrised AHB-Lite slave response generator; drives HREADYOUT/HRESP per AHB-Lite.

---
 rtl/ahb_resp_gen_if.sv | 12 +
 rtl/ahb_resp_gen.sv | 169 ++++++++++++++++
 tb/tb_ahb_resp_gen.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_resp_gen_if.sv
// AHB-Lite slave-side bus signals seen by ahb_resp_gen.
// slave modport faces the response generator; master modport faces the bus/testbench.
interface ahb_resp_gen_if;
  logic       HSEL;
  logic [1:0] HTRANS;
  logic       HREADY;
  logic       HREADYOUT;
  logic       HRESP;

  modport slave  (input HSEL, HTRANS, HREADY, output HREADYOUT, HRESP);
  modport master (output HSEL, HTRANS, HREADY, input HREADYOUT, HRESP);
endinterface

// File: rtl/ahb_resp_gen.sv
// AHB-Lite slave response generator: wait states, two-cycle ERROR, saturating error counter.
// Optional backend timeout is enabled by defining AHB_RESP_TIMEOUT_EN.
module ahb_resp_gen #(
  parameter int MIN_WAIT = 2,
  parameter int TIMEOUT  = 16,
  parameter int CNT_W    = 8
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  ahb_resp_gen_if.slave    bus,
  input  logic             be_done,
  input  logic             be_err,
  input  logic             err_clr,
  output logic             xfer_start,
  output logic             timeout,
  output logic [CNT_W-1:0] err_cnt
);

  if (MIN_WAIT < 0 || MIN_WAIT > 255) begin : g_chk_min_wait
    $error("ahb_resp_gen: MIN_WAIT must be in 0..255");
  end
  if (TIMEOUT < 2) begin : g_chk_timeout
    $error("ahb_resp_gen: TIMEOUT must be >= 2");
  end

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DONE,
    ST_ERR1,
    ST_ERR2
  } state_e;

  localparam logic [7:0] WCNT_INIT = 8'(MIN_WAIT);

  state_e           state_q, state_d;
  logic [7:0]       wcnt_q, wcnt_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             xfer_start_q, xfer_start_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic             accept;
  logic             complete;
  logic             is_err;
  logic             err_inc;

`ifdef AHB_RESP_TIMEOUT_EN
  localparam int               TCNT_W    = $clog2(TIMEOUT);
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT - 1);

  logic [TCNT_W-1:0] tcnt_q, tcnt_d;
  logic              timeout_q, timeout_d;
`endif

  assign accept   = bus.HSEL & bus.HTRANS[1] & bus.HREADY;
  // An early completion is held in done_q/err_q until the wait count expires.
  assign complete = (wcnt_q == 8'd0) & (done_q | be_done);
  assign is_err   = err_q | (be_done & be_err);

  // NOTE: every signal assigned in this block gets a default first, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    wcnt_d       = wcnt_q;
    done_d       = done_q;
    err_d        = err_q;
    xfer_start_d = 1'b0;
    err_inc      = 1'b0;
`ifdef AHB_RESP_TIMEOUT_EN
    tcnt_d       = tcnt_q;
    timeout_d    = 1'b0;
`endif

    unique case (state_q)
      ST_IDLE, ST_DONE, ST_ERR2: begin
        if (accept) begin
          state_d      = ST_WAIT;
          wcnt_d       = WCNT_INIT;
          done_d       = 1'b0;
          err_d        = 1'b0;
          xfer_start_d = 1'b1;
`ifdef AHB_RESP_TIMEOUT_EN
          tcnt_d       = '0;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_WAIT: begin
        if (wcnt_q != 8'd0) wcnt_d = wcnt_q - 8'd1;
        if (be_done) begin
          done_d = 1'b1;
          err_d  = err_q | be_err;
        end
        if (complete) begin
          state_d = is_err ? ST_ERR1 : ST_DONE;
          err_inc = is_err;
        end
`ifdef AHB_RESP_TIMEOUT_EN
        // Completion takes priority over a timeout falling in the same cycle.
        else if (tcnt_q == TCNT_LAST) begin
          state_d   = ST_ERR1;
          err_inc   = 1'b1;
          timeout_d = 1'b1;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
`endif
      end

      ST_ERR1: state_d = ST_ERR2;

      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_inc) begin
      if (err_clr)          err_cnt_d = CNT_W'(1);
      else if (~&err_cnt_q) err_cnt_d = err_cnt_q + 1'b1;
    end else if (err_clr) begin
      err_cnt_d = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q      <= ST_IDLE;
      wcnt_q       <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      xfer_start_q <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      wcnt_q       <= wcnt_d;
      done_q       <= done_d;
      err_q        <= err_d;
      xfer_start_q <= xfer_start_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

`ifdef AHB_RESP_TIMEOUT_EN
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      tcnt_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      tcnt_q    <= tcnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  assign bus.HREADYOUT = ~((state_q == ST_WAIT) | (state_q == ST_ERR1));
  assign bus.HRESP     = (state_q == ST_ERR1) | (state_q == ST_ERR2);
  assign xfer_start    = xfer_start_q;
  assign err_cnt       = err_cnt_q;

endmodule

// File: tb/tb_ahb_resp_gen.sv
// Scoreboard bench for ahb_resp_gen: an 8-bit-counter instance and a 2-bit-counter
// instance share the same stimulus; expected per-cycle outputs are queued then compared.
module tb_ahb_resp_gen;

  localparam logic [1:0] T_IDLE   = 2'b00;
  localparam logic [1:0] T_BUSY   = 2'b01;
  localparam logic [1:0] T_NONSEQ = 2'b10;

  typedef struct packed {
    logic hro;
    logic hresp;
    logic xs;
    logic to;
  } exp_t;

  localparam exp_t X_OKAY  = '{hro: 1'b1, hresp: 1'b0, xs: 1'b0, to: 1'b0};
  localparam exp_t X_START = '{hro: 1'b0, hresp: 1'b0, xs: 1'b1, to: 1'b0};
  localparam exp_t X_WAIT  = '{hro: 1'b0, hresp: 1'b0, xs: 1'b0, to: 1'b0};
  localparam exp_t X_ERR1  = '{hro: 1'b0, hresp: 1'b1, xs: 1'b0, to: 1'b0};
  localparam exp_t X_ERR1T = '{hro: 1'b0, hresp: 1'b1, xs: 1'b0, to: 1'b1};
  localparam exp_t X_ERR2  = '{hro: 1'b1, hresp: 1'b1, xs: 1'b0, to: 1'b0};

  logic       HCLK = 1'b0;
  logic       HRESETn = 1'b0;
  logic       be_done, be_err, err_clr;
  logic       xs_a, to_a, xs_b, to_b;
  logic [7:0] cnt_a;
  logic [1:0] cnt_b;

  ahb_resp_gen_if bus_a ();
  ahb_resp_gen_if bus_b ();

  ahb_resp_gen #(.MIN_WAIT(2), .TIMEOUT(16), .CNT_W(8)) u_dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .bus(bus_a.slave),
    .be_done(be_done), .be_err(be_err), .err_clr(err_clr),
    .xfer_start(xs_a), .timeout(to_a), .err_cnt(cnt_a)
  );

  ahb_resp_gen #(.MIN_WAIT(2), .TIMEOUT(16), .CNT_W(2)) u_dut_w2 (
    .HCLK(HCLK), .HRESETn(HRESETn), .bus(bus_b.slave),
    .be_done(be_done), .be_err(be_err), .err_clr(err_clr),
    .xfer_start(xs_b), .timeout(to_b), .err_cnt(cnt_b)
  );

  always #5 HCLK = ~HCLK;

  int   n_vec = 0;
  int   n_bad = 0;
  int   exp_a = 0;
  int   exp_b = 0;
  exp_t sb[$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic drive(input logic sel, input logic [1:0] tr, input logic rdy,
                       input logic dn, input logic er, input logic clr);
    bus_a.HSEL = sel; bus_a.HTRANS = tr; bus_a.HREADY = rdy;
    bus_b.HSEL = sel; bus_b.HTRANS = tr; bus_b.HREADY = rdy;
    be_done = dn; be_err = er; err_clr = clr;
  endtask

  // One bus cycle: drive at negedge, queue expectation, compare at the next negedge.
  task automatic cyc(input logic sel, input logic [1:0] tr, input logic rdy,
                     input logic dn, input logic er, input logic clr, input exp_t e);
    exp_t got;
    drive(sel, tr, rdy, dn, er, clr);
    sb.push_back(e);
    @(posedge HCLK);
    @(negedge HCLK);
    got = sb.pop_front();
    check("hreadyout", 32'(bus_a.HREADYOUT), 32'(got.hro));
    check("hresp", 32'(bus_a.HRESP), 32'(got.hresp));
    check("xfer_start", 32'(xs_a), 32'(got.xs));
    check("timeout", 32'(to_a), 32'(got.to));
    check("hreadyout_w2", 32'(bus_b.HREADYOUT), 32'(got.hro));
  endtask

  task automatic idle(input exp_t e);
    cyc(1'b0, T_IDLE, 1'b1, 1'b0, 1'b0, 1'b0, e);
  endtask

  task automatic acc(input exp_t e);
    cyc(1'b1, T_NONSEQ, 1'b1, 1'b0, 1'b0, 1'b0, e);
  endtask

  task automatic note_err(input logic clr);
    exp_a = clr ? 1 : ((exp_a == 255) ? 255 : exp_a + 1);
    exp_b = clr ? 1 : ((exp_b == 3) ? 3 : exp_b + 1);
  endtask

  task automatic check_cnt();
    check("err_cnt", 32'(cnt_a), 32'(exp_a));
    check("err_cnt_w2", 32'(cnt_b), 32'(exp_b));
  endtask

  // Accept, two counting WAIT cycles, then done+err -> ERR1 and ERR2 observed.
  task automatic err_xfer(input logic clr);
    acc(X_START);
    idle(X_WAIT);
    idle(X_WAIT);
    cyc(1'b0, T_IDLE, 1'b1, 1'b1, 1'b1, clr, X_ERR1);
    note_err(clr);
    check_cnt();
    idle(X_ERR2);
  endtask

  initial begin
    drive(1'b0, T_IDLE, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge HCLK);
    check("rst_hreadyout", 32'(bus_a.HREADYOUT), 32'd1);
    check("rst_hresp", 32'(bus_a.HRESP), 32'd0);
    check("rst_xfer_start", 32'(xs_a), 32'd0);
    check("rst_timeout", 32'(to_a), 32'd0);
    check_cnt();
    HRESETn = 1'b1;

    // Minimum OKAY transfer with an early completion held until wcnt expires.
    acc(X_START);
    cyc(1'b0, T_IDLE, 1'b1, 1'b1, 1'b0, 1'b0, X_WAIT);
    idle(X_WAIT);
    idle(X_OKAY);
    idle(X_OKAY);

    // Minimum ERROR transfer.
    err_xfer(1'b0);
    idle(X_OKAY);

    // Back-to-back from DONE, then from ERR2.
    acc(X_START);
    idle(X_WAIT);
    cyc(1'b0, T_IDLE, 1'b1, 1'b1, 1'b0, 1'b0, X_WAIT);
    acc(X_OKAY);
    check("b2b_done_start", 32'(xs_a), 32'd0);
    err_xfer(1'b0);
    acc(X_START);
    idle(X_WAIT);
    idle(X_WAIT);
    cyc(1'b0, T_IDLE, 1'b1, 1'b1, 1'b0, 1'b0, X_OKAY);
    idle(X_OKAY);

    // Late completion; be_err without be_done is ignored.
    acc(X_START);
    for (int i = 0; i < 4; i++) idle(X_WAIT);
    cyc(1'b0, T_IDLE, 1'b1, 1'b0, 1'b1, 1'b0, X_WAIT);
    cyc(1'b0, T_IDLE, 1'b1, 1'b1, 1'b0, 1'b0, X_OKAY);
    idle(X_OKAY);
    check_cnt();

    // Early error latched and reported once the wait count expires.
    acc(X_START);
    cyc(1'b0, T_IDLE, 1'b1, 1'b1, 1'b1, 1'b0, X_WAIT);
    idle(X_WAIT);
    idle(X_ERR1);
    note_err(1'b0);
    check_cnt();
    idle(X_ERR2);
    idle(X_OKAY);

`ifdef AHB_RESP_TIMEOUT_EN
    // No completion: 16 WAIT cycles then forced ERROR with a timeout pulse.
    acc(X_START);
    for (int i = 0; i < 15; i++) idle(X_WAIT);
    idle(X_ERR1T);
    note_err(1'b0);
    check_cnt();
    idle(X_ERR2);
    idle(X_OKAY);
    // Completion in the timeout cycle wins.
    acc(X_START);
    for (int i = 0; i < 15; i++) idle(X_WAIT);
    cyc(1'b0, T_IDLE, 1'b1, 1'b1, 1'b0, 1'b0, X_OKAY);
    idle(X_OKAY);
`else
    // No timeout hardware: WAIT holds for 100 cycles until completion.
    acc(X_START);
    for (int i = 0; i < 100; i++) idle(X_WAIT);
    cyc(1'b0, T_IDLE, 1'b1, 1'b1, 1'b0, 1'b0, X_OKAY);
    idle(X_OKAY);
`endif
    check_cnt();

    // Saturation of the 2-bit counter, then clear coincident with an increment.
    for (int i = 0; i < 4; i++) begin
      err_xfer(1'b0);
      idle(X_OKAY);
    end
    err_xfer(1'b1);
    cyc(1'b0, T_IDLE, 1'b1, 1'b0, 1'b0, 1'b1, X_OKAY);
    exp_a = 0;
    exp_b = 0;
    check_cnt();

    // Asynchronous reset in the middle of a WAIT.
    err_xfer(1'b0);
    acc(X_START);
    idle(X_WAIT);
    #2 HRESETn = 1'b0;
    #1;
    check("arst_hreadyout", 32'(bus_a.HREADYOUT), 32'd1);
    check("arst_hresp", 32'(bus_a.HRESP), 32'd0);
    check("arst_xfer_start", 32'(xs_a), 32'd0);
    exp_a = 0;
    exp_b = 0;
    check_cnt();
    @(negedge HCLK);
    HRESETn = 1'b1;

    // Non-accepted requests get zero-wait OKAY.
    cyc(1'b1, T_IDLE, 1'b1, 1'b0, 1'b0, 1'b0, X_OKAY);
    cyc(1'b1, T_BUSY, 1'b1, 1'b0, 1'b0, 1'b0, X_OKAY);
    cyc(1'b1, T_NONSEQ, 1'b0, 1'b0, 1'b0, 1'b0, X_OKAY);
    cyc(1'b0, T_NONSEQ, 1'b1, 1'b0, 1'b0, 1'b0, X_OKAY);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
